// File: rtl/risc_ctrl_pkg.sv
// Shared constants and types for the RISC control path: opcodes, sequencer
// states, PC increment and flag-register bit positions.
package risc_ctrl_pkg;

  localparam logic [5:0] OP_B    = 6'b101011;
  localparam logic [5:0] OP_CALL = 6'b101000;
  localparam logic [5:0] OP_BR   = 6'b100000;
  localparam logic [5:0] OP_BZ   = 6'b110001;
  localparam logic [5:0] OP_BNZ  = 6'b110010;
  localparam logic [5:0] OP_BLTZ = 6'b110000;
  localparam logic [5:0] OP_BCY  = 6'b101001;
  localparam logic [5:0] OP_BNCY = 6'b101010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam int PC_INC = 4;

  // Flag register layout is {zero, sign, carry}.
  localparam int FLAG_Z = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_UPDATE,
    ST_HALT
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of fetch, decode, execute and PC-update signals between the
// sequencer (master) and the surrounding memory/decoder/datapath (slave).
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic              ir_load;
  logic [5:0]        opcode;
  logic              flag_we;
  logic              alu_zero;
  logic              alu_sign;
  logic              alu_carry;
  logic              exec_en;
  logic              ex_done;
  logic [ADDR_W-1:0] branch_imm;
  logic [ADDR_W-1:0] branch_reg;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        flags;
  logic              link_we;
  logic [ADDR_W-1:0] link_addr;
  logic              halted;

  modport master (
    output imem_req, imem_addr, ir_load, exec_en, pc, flags, link_we, link_addr, halted,
    input  imem_ack, opcode, flag_we, alu_zero, alu_sign, alu_carry, ex_done,
           branch_imm, branch_reg
  );

  modport slave (
    input  imem_req, imem_addr, ir_load, exec_en, pc, flags, link_we, link_addr, halted,
    output imem_ack, opcode, flag_we, alu_zero, alu_sign, alu_carry, ex_done,
           branch_imm, branch_reg
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution from the opcode and the latched
// {zero, sign, carry} flags; also flags the register-target jump.
module branch_cond_eval
  import risc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [2:0] flags,
  output logic       taken,
  output logic       is_reg_target
);

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_B, OP_CALL, OP_BR: taken = 1'b1;
      OP_BZ:                taken = flags[FLAG_Z];
      OP_BNZ:               taken = !flags[FLAG_Z];
      OP_BLTZ:              taken = flags[FLAG_S];
      OP_BCY:               taken = flags[FLAG_C];
      OP_BNCY:              taken = !flags[FLAG_C];
      default:              taken = 1'b0;
    endcase
  end

  assign is_reg_target = (opcode == OP_BR);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/UPDATE sequencer owning the PC and flag register.
// Optional HALT state enabled by defining PC_SEQ_HALT_EN.
module pc_sequencer
  import risc_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t                    state;
  state_t                    state_nxt;
  logic [ADDR_W-1:0]         pc_q;
  logic [ADDR_W-1:0]         pc_nxt;
  logic [2:0]                flags_q;
  logic [2:0]                flags_nxt;
  logic signed [ADDR_W-1:0]  branch_off;
  logic [ADDR_W-1:0]         seq_pc;
  logic [ADDR_W-1:0]         target;
  logic                      taken;
  logic                      is_reg_target;
  logic                      imem_req;
  logic                      ir_load;
  logic                      exec_en;
  logic                      link_we;
  logic                      halted;

  branch_cond_eval u_cond (
    .opcode        (bus.opcode),
    .flags         (flags_q),
    .taken         (taken),
    .is_reg_target (is_reg_target)
  );

  // Two's-complement add wraps modulo 2^ADDR_W, so negative offsets need no special case.
  assign branch_off = $signed(bus.branch_imm);
  assign seq_pc     = pc_q + ADDR_W'(PC_INC);
  assign target     = is_reg_target ? bus.branch_reg : (pc_q + $unsigned(branch_off));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      pc_q    <= RESET_PC;
      flags_q <= '0;
    end else begin
      state   <= state_nxt;
      pc_q    <= pc_nxt;
      flags_q <= flags_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    flags_nxt = flags_q;
    imem_req  = 1'b0;
    ir_load   = 1'b0;
    exec_en   = 1'b0;
    link_we   = 1'b0;
    halted    = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_load   = 1'b1;
          state_nxt = ST_DECODE;
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        exec_en = 1'b1;
        if (bus.ex_done) begin
          if (bus.flag_we) flags_nxt = {bus.alu_zero, bus.alu_sign, bus.alu_carry};
          state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        // Branch condition reads flags_q, which already holds this instruction's flag write.
        state_nxt = ST_FETCH;
        link_we   = (bus.opcode == OP_CALL);
        pc_nxt    = taken ? (target & ALIGN_MASK) : seq_pc;
`ifdef PC_SEQ_HALT_EN
        if (bus.opcode == OP_HALT) begin
          state_nxt = ST_HALT;
          pc_nxt    = pc_q;
        end
`endif
      end
`ifdef PC_SEQ_HALT_EN
      ST_HALT: halted = 1'b1;
`endif
      default: state_nxt = ST_FETCH;
    endcase
    // Reset takes effect at the edge, so the strobes must be masked combinationally meanwhile.
    if (rst) begin
      imem_req = 1'b0;
      ir_load  = 1'b0;
      exec_en  = 1'b0;
      link_we  = 1'b0;
      halted   = 1'b0;
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = pc_q;
  assign bus.ir_load   = ir_load;
  assign bus.exec_en   = exec_en;
  assign bus.pc        = pc_q;
  assign bus.flags     = flags_q;
  assign bus.link_we   = link_we;
  assign bus.link_addr = seq_pc;
  assign bus.halted    = halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer; the halt checks follow PC_SEQ_HALT_EN.
module tb_pc_sequencer;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef PC_SEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  flags;
    logic        link;
    logic [31:0] link_addr;
    logic        halted;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ir_cnt  = 0;
  int   lk_cnt  = 0;
  logic [31:0] pc_m;
  logic [2:0]  flags_m;
  exp_t sb[$];

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  pc_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always @(negedge clk) begin
    if (bus.ir_load === 1'b1) ir_cnt <= ir_cnt + 1;
    if (bus.link_we === 1'b1) lk_cnt <= lk_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_taken(input logic [5:0] op, input logic [2:0] f);
    case (op)
      6'b101011, 6'b101000, 6'b100000: return 1'b1;
      6'b110001: return f[2];
      6'b110010: return !f[2];
      6'b110000: return f[1];
      6'b101001: return f[0];
      6'b101010: return !f[0];
      default:   return 1'b0;
    endcase
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic fwe, input logic [2:0] alu,
                           input logic [31:0] imm, input logic [31:0] breg,
                           input int ack_wait, input int done_wait);
    exp_t        e;
    logic [31:0] tgt;
    int          ir0;
    int          lk0;
    e.flags     = fwe ? alu : flags_m;
    e.halted    = HALT_EN && (op == 6'b111111);
    e.link      = (op == 6'b101000);
    e.link_addr = pc_m + 32'd4;
    tgt         = (op == 6'b100000) ? breg : pc_m + imm;
    if (e.halted)                       e.pc = pc_m;
    else if (model_taken(op, e.flags))  e.pc = {tgt[31:2], 2'b00};
    else                                e.pc = pc_m + 32'd4;
    sb.push_back(e);

    ir0 = ir_cnt;
    lk0 = lk_cnt;
    bus.opcode     = op;
    bus.flag_we    = fwe;
    bus.branch_imm = imm;
    bus.branch_reg = breg;
    bus.imem_ack   = 1'b0;
    bus.ex_done    = 1'b0;
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge clk);
      check("fetch_wait_addr", bus.imem_addr, pc_m);
      check("fetch_wait_irld", bus.ir_load, 1'b0);
      step();
    end
    bus.imem_ack = 1'b1;
    @(negedge clk);
    check("fetch_req", bus.imem_req, 1'b1);
    check("fetch_addr", bus.imem_addr, pc_m);
    step();
    bus.imem_ack = 1'b1;  // stray ack in DECODE must be ignored
    @(negedge clk);
    check("decode_quiet", {bus.imem_req, bus.ir_load, bus.exec_en, bus.link_we}, 4'b0);
    step();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < done_wait; i++) begin
      {bus.alu_zero, bus.alu_sign, bus.alu_carry} = ~alu;
      @(negedge clk);
      check("exec_wait_en", bus.exec_en, 1'b1);
      step();
    end
    {bus.alu_zero, bus.alu_sign, bus.alu_carry} = alu;
    bus.ex_done = 1'b1;
    @(negedge clk);
    check("exec_en", bus.exec_en, 1'b1);
    step();
    bus.ex_done = 1'b0;
    {bus.alu_zero, bus.alu_sign, bus.alu_carry} = ~alu;
    @(negedge clk);
    check("update_link_we", bus.link_we, e.link);
    if (e.link) check("update_link_addr", bus.link_addr, e.link_addr);
    step();

    e = sb.pop_front();
    check("pc", bus.pc, e.pc);
    check("flags", bus.flags, e.flags);
    check("halted", bus.halted, e.halted);
    check("ir_load_pulses", 64'(ir_cnt - ir0), 64'd1);
    check("link_pulses", 64'(lk_cnt - lk0), {63'd0, e.link});
    pc_m    = e.pc;
    flags_m = e.flags;
  endtask

  initial begin
    logic [5:0] ops [10];
    ops = '{6'h00, 6'h2B, 6'h28, 6'h20, 6'h31, 6'h32, 6'h30, 6'h29, 6'h2A, 6'h15};

    rst = 1'b1;
    bus.imem_ack = 1'b1;
    bus.ex_done = 1'b0;
    bus.opcode = '0;
    bus.flag_we = 1'b0;
    {bus.alu_zero, bus.alu_sign, bus.alu_carry} = 3'b000;
    bus.branch_imm = '0;
    bus.branch_reg = '0;
    step();
    @(negedge clk);
    check("rst_req", {bus.imem_req, bus.ir_load, bus.exec_en, bus.link_we, bus.halted}, 5'b0);
    step();
    rst = 1'b0;
    check("rst_pc", bus.pc, RESET_PC);
    check("rst_flags", bus.flags, 3'b000);
    check("rst_no_irload", ir_cnt, 0);
    pc_m    = RESET_PC;
    flags_m = 3'b000;

    run_instr(6'h00, 1'b0, 3'b000, 32'h0, 32'h0, 2, 0);          // pc 0 -> 4
    run_instr(6'h00, 1'b1, 3'b100, 32'h0, 32'h0, 0, 1);          // flags = zero
    run_instr(6'h31, 1'b0, 3'b000, 32'h10, 32'h0, 0, 0);         // BZ 0x8 -> 0x18
    run_instr(6'h32, 1'b0, 3'b011, 32'h40, 32'h0, 1, 2);         // BNZ not taken -> 0x1C
    run_instr(6'h00, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0);          // -> 0x20
    run_instr(6'h28, 1'b0, 3'b000, 32'hFFFF_FFF8, 32'h0, 0, 0);  // call -> 0x18
    run_instr(6'h20, 1'b0, 3'b000, 32'h0, 32'h103, 0, 0);        // jump reg -> 0x100
    run_instr(6'h20, 1'b0, 3'b000, 32'h0, 32'hFFFF_FFFC, 0, 0);
    run_instr(6'h00, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0);          // wraps to 0
    run_instr(6'h31, 1'b1, 3'b100, 32'h20, 32'h0, 0, 0);         // branch sees own flags
    run_instr(6'h2B, 1'b0, 3'b000, 32'h6, 32'h0, 0, 0);          // misaligned imm cleared
    run_instr(6'h30, 1'b1, 3'b001, 32'h40, 32'h0, 0, 0);         // BLTZ not taken
    run_instr(6'h29, 1'b0, 3'b000, 32'h40, 32'h0, 0, 0);         // BCY taken
    run_instr(6'h2A, 1'b0, 3'b000, 32'h40, 32'h0, 0, 0);         // BNCY not taken
    for (int i = 0; i < 12; i++)
      run_instr(ops[$urandom_range(0, 9)], 1'($urandom_range(0, 1)), 3'($urandom),
                $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 2));

    // Reset in the middle of EXEC with all flags set.
    run_instr(6'h00, 1'b1, 3'b111, 32'h0, 32'h0, 0, 0);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    step();
    @(negedge clk);
    check("midexec_en", bus.exec_en, 1'b1);
    step();
    rst = 1'b1;
    bus.ex_done = 1'b1;
    bus.flag_we = 1'b1;
    {bus.alu_zero, bus.alu_sign, bus.alu_carry} = 3'b111;
    @(negedge clk);
    check("midexec_rst_en", bus.exec_en, 1'b0);
    step();
    rst = 1'b0;
    bus.ex_done = 1'b0;
    @(negedge clk);
    check("midexec_pc", bus.pc, RESET_PC);
    check("midexec_flags", bus.flags, 3'b000);
    check("midexec_fetch", bus.imem_req, 1'b1);
    step();
    pc_m    = RESET_PC;
    flags_m = 3'b000;

    run_instr(6'h20, 1'b0, 3'b000, 32'h0, 32'h40, 0, 0);
    run_instr(6'h3F, 1'b0, 3'b000, 32'h0, 32'h0, 0, 0);
    if (HALT_EN) begin
      for (int i = 0; i < 3; i++) begin
        bus.imem_ack = 1'b1;
        @(negedge clk);
        check("halt_halted", bus.halted, 1'b1);
        check("halt_no_req", bus.imem_req, 1'b0);
        check("halt_pc", bus.pc, 32'h40);
        step();
      end
      bus.imem_ack = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check("halt_exit_req", bus.imem_req, 1'b1);
      check("halt_exit_halted", bus.halted, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
